// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART receive path
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_PUSH   = 3'd5
    } rx_state_e;

    // Error flags stored alongside each data word: {parity_err, frame_err}
    localparam int FIFO_FLAG_BITS = 2;

    // Clocks per oversample tick, truncated
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    // FIFO entry width for a given data width (data plus both error flags)
    function automatic int entry_width(input int data_bits);
        return data_bits + FIFO_FLAG_BITS;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous show-ahead FIFO with count and full/empty flags
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    // A pop frees a slot on the same edge, so a push into a full FIFO is still taken
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array; contents need no reset because empty_o masks the head
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks push/pop together
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with error-flagged FIFO; UART_RX_TIMEOUT_EN adds idle_timeout
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
`ifdef UART_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_BITS = 4
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_frame_err,
    output logic                          m_parity_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          break_det,
    input  logic                          clr_err
`ifdef UART_RX_TIMEOUT_EN
    ,
    output logic                          idle_timeout
`endif
);

    localparam int      DIV      = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
    localparam int      EW       = entry_width(DATA_BITS);
    localparam int      DIV_W    = $clog2(DIV + 1);
    localparam int      SAMP_W   = $clog2(OVERSAMPLE);
    localparam int      BIT_W    = $clog2(DATA_BITS + 1);
    localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);

    logic                 sync1_q, sync2_q, prev_q;
    logic                 fall;
    logic [DIV_W-1:0]     div_cnt_q;
    logic                 tick;
    rx_state_e            state_q;
    logic [SAMP_W-1:0]    samp_q;
    logic                 v0_q, v1_q;
    logic                 maj;
    logic                 samp_lo, samp_mid, decide, win_end;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_bit_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 push_q;
    logic                 brk_q;
    logic                 stop_ferr;
    logic                 brk_cond;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [EW-1:0]        head;
    logic                 overrun_q;

    // Two-flop synchroniser plus previous-value register for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall = prev_q && !sync2_q;

    // Oversample tick divider, held at zero while idle so every frame starts phase-aligned
    always_ff @(posedge clk) begin
        if (!rst || state_q == S_IDLE) begin
            div_cnt_q <= '0;
        end else if (div_cnt_q == DIV_W'(DIV - 1)) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    assign tick     = (state_q != S_IDLE) && (div_cnt_q == DIV_W'(DIV - 1));
    // samp_q counts ticks already seen in the window, so the Nth tick has samp_q == N-1
    assign samp_lo  = tick && (samp_q == SAMP_W'(OVERSAMPLE/2 - 2));
    assign samp_mid = tick && (samp_q == SAMP_W'(OVERSAMPLE/2 - 1));
    assign decide   = tick && (samp_q == SAMP_W'(OVERSAMPLE/2));
    assign win_end  = tick && (samp_q == SAMP_W'(OVERSAMPLE - 1));
    assign maj      = (v0_q & v1_q) | (v0_q & sync2_q) | (v1_q & sync2_q);

    assign stop_ferr = ferr_q | ~maj;
    assign brk_cond  = (data_q == '0) && stop_ferr && (PAR_MODE == PAR_NONE || !par_bit_q);

    // Frame FSM: window timing, majority sampling, shift register and registered push/break strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            samp_q     <= '0;
            v0_q       <= 1'b1;
            v1_q       <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            push_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            push_q <= 1'b0;
            brk_q  <= 1'b0;
            if (tick) begin
                samp_q <= win_end ? '0 : samp_q + 1'b1;
                if (samp_lo) begin
                    v0_q <= sync2_q;
                end
                if (samp_mid) begin
                    v1_q <= sync2_q;
                end
            end
            case (state_q)
                S_IDLE: begin
                    samp_q <= '0;
                    if (fall) begin
                        state_q    <= S_START;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
                        par_bit_q  <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                    end
                end
                S_START: begin
                    if (decide && maj) begin
                        state_q <= S_IDLE;
                    end else if (win_end) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (decide) begin
                        data_q <= {maj, data_q[DATA_BITS-1:1]};
                    end
                    if (win_end) begin
                        if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                            state_q <= (PAR_MODE == PAR_NONE) ? S_STOP : S_PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (decide) begin
                        par_bit_q <= maj;
                        perr_q    <= (PAR_MODE == PAR_ODD) ? ~(^data_q ^ maj) : (^data_q ^ maj);
                    end
                    if (win_end) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (decide) begin
                        ferr_q <= stop_ferr;
                        // Leave at the last stop centre so the next start edge is never missed
                        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                            state_q <= S_PUSH;
                            push_q  <= ~brk_cond;
                            brk_q   <= brk_cond;
                        end
                    end
                    if (win_end) begin
                        stop_cnt_q <= 1'b1;
                    end
                end
                S_PUSH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pop = m_valid && m_ready;

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (push_q),
        .push_data_i ({perr_q, ferr_q, data_q}),
        .pop_i       (pop),
        .pop_data_o  (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Sticky overrun; a drop in the same cycle as clr_err keeps it set
    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else if (push_q && fifo_full && !pop) begin
            overrun_q <= 1'b1;
        end else if (clr_err) begin
            overrun_q <= 1'b0;
        end
    end

    assign m_valid      = !fifo_empty;
    assign m_data       = head[DATA_BITS-1:0];
    assign m_frame_err  = head[DATA_BITS];
    assign m_parity_err = head[DATA_BITS+1];
    assign overrun      = overrun_q;
    assign break_det    = brk_q;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE * DIV;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_armed_q;
    logic            idle_to_q;

    // End-of-message detector: armed by a push, counts idle clocks, fires once
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q   <= '0;
            to_armed_q <= 1'b0;
            idle_to_q  <= 1'b0;
        end else begin
            idle_to_q <= 1'b0;
            if (push_q) begin
                to_armed_q <= 1'b1;
                to_cnt_q   <= '0;
            end else if (fall || state_q != S_IDLE) begin
                to_cnt_q <= '0;
            end else if (to_armed_q) begin
                if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
                    idle_to_q  <= 1'b1;
                    to_armed_q <= 1'b0;
                    to_cnt_q   <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end
        end
    end

    assign idle_timeout = idle_to_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param against a frame-level model
module tb_uart_rx_param;

    localparam int CLK_HZ = 50_000_000;
    localparam int A_BAUD = 115200;
    localparam int A_OS   = 16;
    localparam int A_BIT  = A_OS * (CLK_HZ / (A_BAUD * A_OS));
    localparam int B_BAUD = 781250;
    localparam int B_OS   = 8;
    localparam int B_BIT  = B_OS * (CLK_HZ / (B_BAUD * B_OS));
    localparam int B_DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx_a, rx_b;
    logic       m_ready_a, m_ready_b;
    logic       clr_a, clr_b;
    logic [7:0] m_data_a, m_data_b;
    logic       m_frame_err_a, m_frame_err_b;
    logic       m_parity_err_a, m_parity_err_b;
    logic       m_valid_a, m_valid_b;
    logic [4:0] fifo_count_a, fifo_count_b;
    logic       overrun_a, overrun_b;
    logic       break_det_a, break_det_b;
`ifdef UART_RX_TIMEOUT_EN
    logic       idle_to_a, idle_to_b;
`endif

    uart_rx_param u_a (
        .clk(clk), .rst(rst), .rx(rx_a),
        .m_data(m_data_a), .m_frame_err(m_frame_err_a), .m_parity_err(m_parity_err_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .fifo_count(fifo_count_a),
        .overrun(overrun_a), .break_det(break_det_a), .clr_err(clr_a)
`ifdef UART_RX_TIMEOUT_EN
        , .idle_timeout(idle_to_a)
`endif
    );

    uart_rx_param #(
        .BAUDRATE(B_BAUD), .OVERSAMPLE(B_OS), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(B_DEPTH)
    ) u_b (
        .clk(clk), .rst(rst), .rx(rx_b),
        .m_data(m_data_b), .m_frame_err(m_frame_err_b), .m_parity_err(m_parity_err_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .fifo_count(fifo_count_b),
        .overrun(overrun_b), .break_det(break_det_b), .clr_err(clr_b)
`ifdef UART_RX_TIMEOUT_EN
        , .idle_timeout(idle_to_b)
`endif
    );

    int         n_checks = 0;
    int         n_fail = 0;
    longint     cyc = 0;
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    logic [9:0] ent;
    int         brk_cnt_a = 0, brk_cnt_b = 0;
    int         brk_exp_a = 0, brk_exp_b = 0;
    bit         ovr_exp_b = 1'b0;
    int         to_cnt_a = 0;
    longint     to_cyc_a = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer/scoreboard: sampled after inputs settle, before the next active edge
    always @(negedge clk) begin
        #1;
        if (rst) begin
            if (m_valid_a && m_ready_a) begin
                if (exp_a.size() == 0) check("a_unexpected_entry", exp_a.size(), 1);
                else begin
                    ent = exp_a.pop_front();
                    check("a_entry", {m_parity_err_a, m_frame_err_a, m_data_a}, ent);
                end
            end
            if (m_valid_b && m_ready_b) begin
                if (exp_b.size() == 0) check("b_unexpected_entry", exp_b.size(), 1);
                else begin
                    ent = exp_b.pop_front();
                    check("b_entry", {m_parity_err_b, m_frame_err_b, m_data_b}, ent);
                end
            end
            if (break_det_a) brk_cnt_a++;
            if (break_det_b) brk_cnt_b++;
`ifdef UART_RX_TIMEOUT_EN
            if (idle_to_a) begin
                if (to_cnt_a == 0) to_cyc_a = cyc;
                to_cnt_a++;
            end
`endif
        end
    end

    task automatic drive(input bit on_b, input logic v, input int n);
        if (on_b) rx_b = v;
        else rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    // Frame-level model: expected entry derived from the bits actually put on the line
    task automatic send_frame(input bit on_b, input logic [7:0] data, input bit par_good,
                              input logic [1:0] stops, input int glitch_bit);
        int   bitclk;
        logic bits[$];
        logic par_bit, perr, ferr, brk;
        bitclk  = on_b ? B_BIT : A_BIT;
        par_bit = ($countones(data) % 2) == 1;
        if (!par_good) par_bit = ~par_bit;
        perr = on_b && !par_good;
        ferr = on_b ? (stops != 2'b11) : (stops[0] == 1'b0);
        brk  = (data == 8'h00) && ferr && (!on_b || par_bit == 1'b0);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (on_b) bits.push_back(par_bit);
        bits.push_back(stops[0]);
        if (on_b) bits.push_back(stops[1]);
        if (brk) begin
            if (on_b) brk_exp_b++;
            else brk_exp_a++;
        end else if (on_b) begin
            if (!m_ready_b && exp_b.size() >= B_DEPTH) ovr_exp_b = 1'b1;
            else exp_b.push_back({perr, ferr, data});
        end else begin
            exp_a.push_back({perr, ferr, data});
        end
        for (int i = 0; i < bits.size(); i++) begin
            if (i == glitch_bit) begin
                drive(on_b, bits[i], bitclk/2 - 10);
                drive(on_b, ~bits[i], 20);
                drive(on_b, bits[i], bitclk - bitclk/2 + 10 - 20);
            end else begin
                drive(on_b, bits[i], bitclk);
            end
        end
    endtask

    task automatic wait_drain(input bit on_b, input int budget);
        int k;
        k = 0;
        while (k < budget && (on_b ? (exp_b.size() != 0 || m_valid_b) : (exp_a.size() != 0 || m_valid_a))) begin
            @(negedge clk);
            k++;
        end
        if (on_b) check("b_drain_done", exp_b.size(), 0);
        else check("a_drain_done", exp_a.size(), 0);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int     lat;
        longint t0;
        int     brk_before;
        rst = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
        m_ready_a = 1'b1; m_ready_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("rst_m_valid_a", m_valid_a, 0);
        check("rst_fifo_count_a", fifo_count_a, 0);
        check("rst_overrun_a", overrun_a, 0);
        check("rst_break_det_a", break_det_a, 0);
        check("rst_m_data_a", {m_parity_err_a, m_frame_err_a, m_data_a}, 0);
        check("rst_fifo_count_b", fifo_count_b, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 2 * A_BIT);

        // 8N1 back-to-back 0x55, 0xA3 with first-entry latency
        lat = -1;
        t0 = cyc;
        fork
            begin
                send_frame(0, 8'h55, 1'b1, 2'b11, -1);
                send_frame(0, 8'hA3, 1'b1, 2'b11, -1);
            end
            begin
                for (int i = 0; i < 6000; i++) begin
                    @(negedge clk);
                    #2;
                    if (m_valid_a) begin
                        lat = int'(cyc - t0);
                        break;
                    end
                end
            end
        join
        check($sformatf("a_latency_window_lat%0d", lat), (lat >= 9 * A_BIT) && (lat <= 21 * A_BIT / 2), 1);
        wait_drain(0, 2000);

        // Short low pulse is a false start; a glitch on one sample is outvoted
        drive(0, 1'b0, 150);
        drive(0, 1'b1, 2 * A_BIT);
        check("a_false_start_count", fifo_count_a, 0);
        check("a_false_start_valid", m_valid_a, 0);
        send_frame(0, 8'h3C, 1'b1, 2'b11, 4);
        send_frame(0, 8'hC3, 1'b1, 2'b11, 7);
        wait_drain(0, 2000);

        // Break: line low for 12 bit times, then resync on 0x31
        brk_before = brk_cnt_a;
        brk_exp_a++;
        drive(0, 1'b0, 12 * A_BIT);
        drive(0, 1'b1, 2 * A_BIT);
        check("a_break_pulses", brk_cnt_a - brk_before, 1);
        check("a_break_no_push", fifo_count_a, 0);
        send_frame(0, 8'h31, 1'b1, 2'b11, -1);
        wait_drain(0, 2000);

        // Random bytes, back to back
        for (int i = 0; i < 3; i++) send_frame(0, 8'($urandom), 1'b1, 2'b11, -1);
        wait_drain(0, 2000);

`ifdef UART_RX_TIMEOUT_EN
        to_cnt_a = 0;
        t0 = cyc;
        send_frame(0, 8'h0D, 1'b1, 2'b11, -1);
        drive(0, 1'b1, 10 * A_BIT);
        check("a_timeout_pulses", to_cnt_a, 1);
        check($sformatf("a_timeout_window_at%0d", int'(to_cyc_a - t0)),
              (to_cyc_a - t0 >= 13 * A_BIT) && (to_cyc_a - t0 <= 29 * A_BIT / 2), 1);
`endif
        check("a_break_total", brk_cnt_a, brk_exp_a);

        // Even parity, 2 stop bits: 0x07 with wrong then correct parity
        drive(1, 1'b1, 2 * B_BIT);
        send_frame(1, 8'h07, 1'b0, 2'b11, -1);
        send_frame(1, 8'h07, 1'b1, 2'b11, -1);
        // Random data with occasional parity and stop-bit errors (zero data may form a break)
        for (int i = 0; i < 12; i++) begin
            send_frame(1, ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                       $urandom_range(0, 3) != 0,
                       ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b11, -1);
        end
        wait_drain(1, 2000);
        check("b_break_total", brk_cnt_b, brk_exp_b);
        check("b_no_overrun_yet", overrun_b, 0);

        // Overrun: 17 frames into a 16-deep FIFO with the consumer stalled
        m_ready_b = 1'b0;
        for (int i = 0; i < 17; i++) send_frame(1, 8'($urandom), $urandom_range(0, 1) == 1, 2'b11, -1);
        drive(1, 1'b1, B_BIT);
        #1;
        check("b_full_count", fifo_count_b, exp_b.size());
        check("b_overrun_set", overrun_b, ovr_exp_b);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        #1;
        check("b_overrun_cleared", overrun_b, 0);
        m_ready_b = 1'b1;
        wait_drain(1, 200);
        check("b_drained_count", fifo_count_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
